cpumc_arb: RTL
==============

# cpumc_arb

Cycle-level arbiter for the CPU memory-controller bus (cpumc), shared by the CPU core, the sprite DMA engine and the APU DMC sample fetcher. It decides which requester drives cpumc address/data/r_nw each clock and de-asserts CPU ready while a DMA owns the bus. Bus ownership changes only on cycles where the 6502 can legally halt. It sits between the CPU/DMA blocks and the CPU memory controller and counts CPU stall cycles for the debugger.

## Interface
Parameters:
- CNT_W, 16, width of stall counter

Ports:
- clk_in  in  1  100MHz system clock
- rst_in  in  1  reset; asynchronous, active-high
- cpu_a_in  in  16  CPU address
- cpu_d_in  in  8  CPU write data
- cpu_r_nw_in  in  1  CPU read(1)/write(0)
- cpu_rdy_out  out  1  CPU ready; 0 stalls CPU
- spr_req_in  in  1  sprite DMA wants bus (its active flag)
- spr_a_in / spr_d_in / spr_r_nw_in  in  16/8/1  sprite DMA bus
- spr_gnt_out  out  1  sprite DMA owns bus; DMA holds its state while low
- dmc_req_in  in  1  DMC sample fetch request (level, held until ack)
- dmc_a_in  in  16  DMC sample address
- dmc_d_out  out  8  fetched sample byte
- dmc_ack_out  out  1  one-cycle pulse, dmc_d_out valid
- cpumc_dout_in  in  8  memory-controller read data
- cpumc_a_out / cpumc_d_out / cpumc_r_nw_out  out  16/8/1  muxed bus to memory controller
- stall_clr_in  in  1  synchronous clear of stall counter
- stall_cnt_out  out  CNT_W  saturating count of cycles with cpu_rdy_out=0

## Operation
- States: IDLE (CPU owns bus, rdy=1), HALT (rdy=0, CPU still owns bus), SPR, DMC_A, DMC_D.
- IDLE -> HALT when spr_req_in or dmc_req_in.
- HALT: CPU bus passes through. Exit when cpu_r_nw_in=1 in a HALT cycle (the 6502 cannot halt on writes): to DMC_A if dmc_req_in, else SPR if spr_req_in. If both requests are gone, return to IDLE.
- SPR: spr bus muxed out, spr_gnt_out=1. Leave to IDLE when spr_req_in=0. Leave to DMC_A when dmc_req_in=1 and spr_r_nw_in=0 (last cycle of a sprite read/write unit, so a unit is never split).
- DMC_A: cpumc_a_out=dmc_a_in, r_nw=1.
- DMC_D: cpumc_a_out=dmc_a_in, r_nw=1, latch cpumc_dout_in into dmc_d_out.
- After DMC_D: go to SPR if spr_req_in, else IDLE. dmc_ack_out=1 on the first cycle after DMC_D.
- Priority: DMC > SPR. The CPU never preempts a DMA.
- Non-owning requesters see 0 on the bus outputs. Unowned cycles (HALT excepted) drive a=0, d=0, r_nw=1.
- Stall counter: +1 per cycle with cpu_rdy_out=0, saturates at all-ones. stall_clr_in wins over increment.

## Timing
- State, grant, ack, dmc_d_out and counter are registered. The bus mux is combinational from the registered state.
- cpu_rdy_out = (state==IDLE). It drops the cycle after a request is first seen in IDLE.
- Minimum DMC steal from IDLE: HALT(>=1) + DMC_A + DMC_D = 3 cycles of rdy=0.
- Return to CPU: rdy=1 the cycle after the last DMA cycle.
- Simultaneous spr/dmc requests in IDLE: DMC served first, then SPR without returning to IDLE.
- dmc_req_in dropping in DMC_A/DMC_D: the fetch still completes and is acked.
- Reset (any state, mid-transfer): IDLE, rdy=1, gnt=0, ack=0, dmc_d_out=0, stall_cnt=0. cpumc outputs follow the CPU inputs. The aborted DMA is not resumed.

## Structure
- Package cpumc_arb_pkg: state encoding (3-bit localparams S_IDLE..S_DMC_D) and bus-width constants (ADDR_W=16, DATA_W=8), shared with sprdma and the APU.
- One natural sub-module: cpumc_bus_mux (combinational 3-source bus select keyed by state). The FSM, latch and counter live in cpumc_arb.

## Test plan
- CPU only, no requests: cpumc outputs equal cpu inputs every cycle, rdy=1, stall_cnt=0.
- spr_req_in rises while the CPU writes for 2 cycles, then reads: HALT lasts 3 cycles, SPR starts on the next cycle, spr_gnt_out=1, rdy=0 until spr_req_in falls, then rdy=1 the next cycle.
- dmc_req_in with dmc_a_in=0xC123 and memory returning 0x5A: DMC_A/DMC_D drive 0xC123 with r_nw=1, then dmc_ack_out pulses once with dmc_d_out=0x5A.
- DMC request mid-sprite-DMA at a read cycle: SPR continues to its write cycle, then DMC_A/DMC_D run, then SPR resumes. spr_gnt_out=0 for exactly 2 cycles and no sprite byte is lost (256 writes to 0x2004).
- Both requests on the same cycle: DMC served first, SPR follows directly, and rdy stays 0 throughout.
- Stall counter preset near all-ones, then 5 stall cycles: counter holds at 0xFFFF. stall_clr_in with a concurrent stall cycle gives 0. Async reset asserted in DMC_D gives IDLE, rdy=1 and no ack.

Source files
------------

// File: rtl/cpumc_arb_pkg.sv
// Shared encodings for the cpumc bus arbiter: state codes, bus widths, bus beat struct.
// Also used by the sprite DMA and APU blocks so they agree on widths.
package cpumc_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_HALT  = 3'd1;
    localparam state_t S_SPR   = 3'd2;
    localparam state_t S_DMC_A = 3'd3;
    localparam state_t S_DMC_D = 3'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              r_nw;
    } bus_t;

endpackage

// File: rtl/cpumc_bus_mux.sv
// Three-source cpumc bus select keyed by the arbiter's registered state.
// The CPU keeps the bus in HALT so its in-flight cycle completes.
module cpumc_bus_mux
    import cpumc_arb_pkg::*;
(
    input  state_t            state_i,
    input  bus_t              cpu_i,
    input  bus_t              spr_i,
    input  logic [ADDR_W-1:0] dmc_a_i,
    output bus_t              bus_o
);

    always_comb begin
        bus_o = '{a: '0, d: '0, r_nw: 1'b1};
        case (state_i)
            S_IDLE, S_HALT:   bus_o = cpu_i;
            S_SPR:            bus_o = spr_i;
            S_DMC_A, S_DMC_D: bus_o = '{a: dmc_a_i, d: '0, r_nw: 1'b1};
            default:          ;
        endcase
    end

endmodule

// File: rtl/cpumc_arb.sv
// CPU / sprite DMA / DMC bus arbiter for the CPU memory controller.
// Owns the halt FSM, the DMC sample latch and the saturating stall counter.
module cpumc_arb
    import cpumc_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] cpu_a_in,
    input  logic [DATA_W-1:0] cpu_d_in,
    input  logic              cpu_r_nw_in,
    output logic              cpu_rdy_out,
    input  logic              spr_req_in,
    input  logic [ADDR_W-1:0] spr_a_in,
    input  logic [DATA_W-1:0] spr_d_in,
    input  logic              spr_r_nw_in,
    output logic              spr_gnt_out,
    input  logic              dmc_req_in,
    input  logic [ADDR_W-1:0] dmc_a_in,
    output logic [DATA_W-1:0] dmc_d_out,
    output logic              dmc_ack_out,
    input  logic [DATA_W-1:0] cpumc_dout_in,
    output logic [ADDR_W-1:0] cpumc_a_out,
    output logic [DATA_W-1:0] cpumc_d_out,
    output logic              cpumc_r_nw_out,
    input  logic              stall_clr_in,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    state_t            state_q, state_d;
    logic              gnt_q;
    logic              ack_q;
    logic [DATA_W-1:0] dmc_d_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              dmc_req;
    bus_t              cpu_bus, spr_bus, mc_bus;

    // The DMC still holds its request during the ack cycle; that is the
    // request just served, so it must not start a second fetch.
    assign dmc_req     = dmc_req_in & ~ack_q;
    assign cpu_rdy_out = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (spr_req_in || dmc_req) state_d = S_HALT;
            S_HALT: begin
                if (!spr_req_in && !dmc_req) state_d = S_IDLE;
                else if (cpu_r_nw_in)        state_d = dmc_req ? S_DMC_A : S_SPR;
            end
            S_SPR: begin
                if (!spr_req_in)                 state_d = S_IDLE;
                else if (dmc_req && !spr_r_nw_in) state_d = S_DMC_A;
            end
            S_DMC_A: state_d = S_DMC_D;
            S_DMC_D: state_d = spr_req_in ? S_SPR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_clr_in)                       stall_d = '0;
        else if (!cpu_rdy_out && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            ack_q   <= 1'b0;
            dmc_d_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= (state_d == S_SPR);
            ack_q   <= (state_q == S_DMC_D);
            if (state_q == S_DMC_D) dmc_d_q <= cpumc_dout_in;
            stall_q <= stall_d;
        end
    end

    assign cpu_bus = '{a: cpu_a_in, d: cpu_d_in, r_nw: cpu_r_nw_in};
    assign spr_bus = '{a: spr_a_in, d: spr_d_in, r_nw: spr_r_nw_in};

    cpumc_bus_mux u_mux (
        .state_i (state_q),
        .cpu_i   (cpu_bus),
        .spr_i   (spr_bus),
        .dmc_a_i (dmc_a_in),
        .bus_o   (mc_bus)
    );

    assign cpumc_a_out    = mc_bus.a;
    assign cpumc_d_out    = mc_bus.d;
    assign cpumc_r_nw_out = mc_bus.r_nw;
    assign spr_gnt_out    = gnt_q;
    assign dmc_ack_out    = ack_q;
    assign dmc_d_out      = dmc_d_q;
    assign stall_cnt_out  = stall_q;

endmodule
